// File: rtl/multicycle_main_control.sv
// Moore main control FSM for the multi-cycle processor: sequences each
// instruction through fetch/decode/execute/memory/write-back and counts retirements.
module multicycle_main_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       opcode,
  input  logic [8:0]       func,
  input  logic             zero,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       aluop,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_LOAD_RD  = 4'd2,
    S_LOAD_WB  = 4'd3,
    S_STORE    = 4'd4,
    S_JUMP     = 4'd5,
    S_BRZ_TEST = 4'd6,
    S_BRZ_TAKE = 4'd7,
    S_C_EXEC   = 4'd8,
    S_C_WB     = 4'd9,
    S_D_EXEC   = 4'd10,
    S_D_WB     = 4'd11,
    S_BAD12    = 4'd12,
    S_BAD13    = 4'd13,
    S_BAD14    = 4'd14,
    S_BAD15    = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
  } ctrl_t;

  localparam logic [1:0] PC_INC = 2'b00, PC_ALU  = 2'b01;
  localparam logic [1:0] B_ZERO = 2'b00, B_RI    = 2'b01, B_IMM = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB  = 2'b01, OP_FUNC = 2'b10, OP_OPC = 2'b11;

  state_t cur, nxt;
  ctrl_t  ctl;
  logic   retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_FETCH;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        casez (opcode)
          4'b0000: nxt = S_LOAD_RD;
          4'b0001: nxt = S_STORE;
          4'b0010: nxt = S_JUMP;
          4'b0100: nxt = S_BRZ_TEST;
          4'b1000: nxt = (func != 9'd0) ? S_C_EXEC : S_FETCH;
          4'b11??: nxt = S_D_EXEC;
          default: nxt = S_FETCH;
        endcase
      end
      S_LOAD_RD:  nxt = S_LOAD_WB;
      S_BRZ_TEST: nxt = zero ? S_BRZ_TAKE : S_FETCH;
      S_C_EXEC:   nxt = S_C_WB;
      S_D_EXEC:   nxt = S_D_WB;
      default:    nxt = S_FETCH;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (cur)
      S_FETCH: begin
        ctl.mem_read = 1'b1;
        ctl.ir_write = 1'b1;
        ctl.pc_write = 1'b1;
        ctl.pc_src   = PC_INC;
      end
      S_LOAD_RD: begin
        ctl.iord     = 1'b1;
        ctl.mem_read = 1'b1;
      end
      S_LOAD_WB: begin
        ctl.iord       = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
      end
      S_STORE: begin
        ctl.iord      = 1'b1;
        ctl.mem_write = 1'b1;
      end
      S_JUMP, S_BRZ_TAKE: begin
        ctl.aluop     = OP_ADD;
        ctl.alu_src_b = B_IMM;
        ctl.pc_write  = 1'b1;
        ctl.pc_src    = PC_ALU;
      end
      // R0 - 0 drives the zero flag for the branch decision
      S_BRZ_TEST: begin
        ctl.aluop     = OP_SUB;
        ctl.alu_src_b = B_ZERO;
      end
      S_C_EXEC: begin
        ctl.aluop     = OP_FUNC;
        ctl.alu_src_b = B_RI;
      end
      S_C_WB: begin
        ctl.aluop     = OP_FUNC;
        ctl.alu_src_b = B_RI;
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = func[0];
      end
      S_D_EXEC: begin
        ctl.aluop     = OP_OPC;
        ctl.alu_src_b = B_IMM;
      end
      S_D_WB: begin
        ctl.aluop     = OP_OPC;
        ctl.alu_src_b = B_IMM;
        ctl.reg_write = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  // Strobes are gated by reset so nothing fires while rst_n is low.
  assign pc_write   = ctl.pc_write  & rst_n;
  assign ir_write   = ctl.ir_write  & rst_n;
  assign mem_read   = ctl.mem_read  & rst_n;
  assign mem_write  = ctl.mem_write & rst_n;
  assign reg_write  = ctl.reg_write & rst_n;
  assign pc_src     = ctl.pc_src;
  assign iord       = ctl.iord;
  assign reg_dst    = ctl.reg_dst;
  assign mem_to_reg = ctl.mem_to_reg;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign aluop      = ctl.aluop;
  assign state      = cur;

  assign retire = (cur != S_FETCH) && (nxt == S_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_count <= '0;
    else if (retire) instr_count <= instr_count + 1'b1;
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Random-instruction bench: an instruction-level model predicts each state
// trace, the per-state control word and the retirement count.
module tb_multicycle_main_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  opcode = '0;
  logic [8:0]  func = '0;
  logic        zero = 1'b0;

  logic        pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  pc_src, alu_src_b, aluop;
  logic [3:0]  state;
  logic [15:0] instr_count;

  logic        pc_write4, iord4, mem_read4, mem_write4, ir_write4, reg_write4, reg_dst4, mem_to_reg4, alu_src_a4;
  logic [1:0]  pc_src4, alu_src_b4, aluop4;
  logic [3:0]  state4;
  logic [3:0]  instr_count4;

  multicycle_main_control #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
    .pc_write(pc_write), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .aluop(aluop), .state(state), .instr_count(instr_count)
  );

  multicycle_main_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
    .pc_write(pc_write4), .pc_src(pc_src4), .iord(iord4), .mem_read(mem_read4),
    .mem_write(mem_write4), .ir_write(ir_write4), .reg_write(reg_write4),
    .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4), .alu_src_a(alu_src_a4),
    .alu_src_b(alu_src_b4), .aluop(aluop4), .state(state4), .instr_count(instr_count4)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int retired = 0;

  wire [14:0] obs = {pc_write, pc_src, iord, mem_read, mem_write, ir_write,
                     reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, aluop};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Expected control word for a state, straight from the state table.
  function automatic logic [14:0] exp_ctl(input int s, input logic f0);
    logic pw, io, mr, mw, iw, rw, rd, m2r;
    logic [1:0] ps, sb, op;
    {pw, io, mr, mw, iw, rw, rd, m2r} = '0;
    ps = 2'd0; sb = 2'd0; op = 2'd0;
    if (s == 0) begin mr = 1; iw = 1; pw = 1; end
    if (s == 2 || s == 3 || s == 4) io = 1;
    if (s == 2) mr = 1;
    if (s == 3) begin m2r = 1; rw = 1; end
    if (s == 4) mw = 1;
    if (s == 5 || s == 7) begin sb = 2; pw = 1; ps = 1; end
    if (s == 6) op = 1;
    if (s == 8 || s == 9) begin op = 2; sb = 1; end
    if (s == 9) begin rw = 1; rd = f0; end
    if (s == 10 || s == 11) begin op = 3; sb = 2; end
    if (s == 11) rw = 1;
    return {pw, ps, io, mr, mw, iw, rw, rd, m2r, 1'b0, sb, op};
  endfunction

  task automatic check_cnt(input string tag);
    chk({tag, ".cnt16"}, 32'(instr_count), 32'(retired % 65536));
    chk({tag, ".cnt4"}, 32'(instr_count4), 32'(retired % 16));
  endtask

  // Enter reset mid-cycle, hold 3 clocks, release; the machine should sit in FETCH with strobes off.
  task automatic do_reset();
    rst_n = 1'b0;
    retired = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rst.state", 32'(state), 32'd0);
      chk("rst.ctl", 32'(obs), 32'd0);
      check_cnt("rst");
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    #1;
    chk("rel.ctl", 32'(obs), 32'(exp_ctl(0, 1'b0)));
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [8:0] f, input bit zt, input bit may_abort);
    int seq[$];
    int ab;
    seq = '{0, 1};
    if (op == 0) seq = '{0, 1, 2, 3};
    else if (op == 1) seq = '{0, 1, 4};
    else if (op == 2) seq = '{0, 1, 5};
    else if (op == 4) seq = zt ? '{0, 1, 6, 7} : '{0, 1, 6};
    else if (op == 8 && f != 0) seq = '{0, 1, 8, 9};
    else if (op >= 12) seq = '{0, 1, 10, 11};
    ab = (may_abort && $urandom_range(0, 9) == 0) ? $urandom_range(1, seq.size() - 1) : -1;
    for (int i = 0; i < seq.size(); i++) begin
      if (i == 0) begin opcode = op; func = f; end
      zero = (seq[i] == 6) ? zt : 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("op%0h.s%0d.state", op, i), 32'(state), 32'(seq[i]));
      chk($sformatf("op%0h.s%0d.ctl", op, i), 32'(obs), 32'(exp_ctl(seq[i], f[0])));
      if (i == ab) begin
        do_reset();
        return;
      end
      @(posedge clk); #1;
    end
    retired++;
    chk($sformatf("op%0h.end", op), 32'(state), 32'd0);
    check_cnt($sformatf("op%0h", op));
  endtask

  initial begin
    logic [3:0] rop;
    logic [8:0] rf;
    int r;
    @(posedge clk); #1;
    do_reset();

    run_instr(4'b1101, 9'h000, 1'b0, 1'b0);
    run_instr(4'b1000, 9'h001, 1'b0, 1'b0);
    run_instr(4'b1000, 9'h004, 1'b0, 1'b0);
    run_instr(4'b1000, 9'h000, 1'b0, 1'b0);
    run_instr(4'b0100, 9'h000, 1'b1, 1'b0);
    run_instr(4'b0100, 9'h000, 1'b0, 1'b0);
    run_instr(4'b0000, 9'h000, 1'b0, 1'b0);
    run_instr(4'b0001, 9'h000, 1'b0, 1'b0);
    run_instr(4'b0010, 9'h000, 1'b0, 1'b0);
    run_instr(4'b0111, 9'h000, 1'b0, 1'b0);

    // LOAD aborted in LOAD_RD: reset must suppress the write-back and clear the count
    opcode = 4'b0000; func = '0;
    #1; chk("abort.ctl0", 32'(obs), 32'(exp_ctl(0, 1'b0)));
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort.state2", 32'(state), 32'd2);
    do_reset();
    chk("abort.state", 32'(state), 32'd0);
    chk("abort.rw", 32'(reg_write), 32'd0);

    for (int k = 0; k < 16; k++) run_instr(4'b0111, 9'h000, 1'b0, 1'b0);
    chk("wrap.cnt4", 32'(instr_count4), 32'd0);
    chk("wrap.cnt16", 32'(instr_count), 32'd16);

    for (int k = 0; k < 300; k++) begin
      rop = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      rf = (r == 9) ? 9'd0 : 9'(1 << r);
      run_instr(rop, rf, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Moore-style main control FSM for the multi-cycle processor.
- Sequences fetch / decode / execute / memory / write-back for each instruction, using the opcode and func fields held in the instruction register.
- Drives the datapath enables and muxes, and produces the 2-bit aluop consumed directly downstream by the ALU control decoder.
- Also keeps a retired-instruction counter for bring-up and performance checks.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  4  IR[15:12]; stable from the cycle after FETCH.
- func  in  9  IR[8:0]; one-hot Type-C function field.
- zero  in  1  ALU zero flag, combinational from the current ALU result.
- pc_write  out  1  PC load enable.
- pc_src  out  2  PC source: 00 = PC+1 (dedicated incrementer), 01 = ALU result.
- iord  out  1  memory address select: 0 = PC, 1 = IR address field.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load enable.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  write destination: 0 = R0, 1 = Ri field of IR.
- mem_to_reg  out  1  write-back source: 1 = memory data, 0 = ALU result.
- alu_src_a  out  1  ALU A operand: 0 = R0 latch, 1 = Ri latch.
- alu_src_b  out  2  ALU B operand: 00 = constant 0, 01 = Ri latch, 10 = zero-extended immediate.
- aluop  out  2  to ALU control: 00 add/pass, 01 sub, 10 func decode, 11 opcode decode.
- state  out  4  current state encoding, for debug.
- instr_count  out  CNT_W  count of retired instructions.

Behaviour:
- Opcode map:
  - 0000 LOAD
  - 0001 STORE
  - 0010 JUMP
  - 0100 BRZ
  - 1000 TYPE_C
  - 11xx TYPE_D
  - all other opcodes are illegal and are treated as NOP.
- Outputs are decoded from the state register only. Any output not listed for a state is 0.
- States (encoding in brackets) and transitions:
  - FETCH [0]: mem_read, ir_write, pc_write, pc_src=00. The ALU is not used. Next: DECODE.
  - DECODE [1]: register latches load. Next state by opcode:
    - LOAD -> LOAD_RD
    - STORE -> STORE
    - JUMP -> JUMP
    - BRZ -> BRZ_TEST
    - TYPE_C with func != 0 -> C_EXEC
    - TYPE_D -> D_EXEC
    - illegal opcode, or TYPE_C with func == 0 -> FETCH (retires).
  - LOAD_RD [2]: iord=1, mem_read. Next: LOAD_WB.
  - LOAD_WB [3]: iord=1, mem_to_reg=1, reg_write, reg_dst=0. Next: FETCH.
  - STORE [4]: iord=1, mem_write. Next: FETCH.
  - JUMP [5]: aluop=00, alu_src_b=10; ALU control passes B for opcode 0010. pc_write, pc_src=01. Next: FETCH.
  - BRZ_TEST [6]: aluop=01, alu_src_a=0, alu_src_b=00, so R0-0 drives zero. Next: BRZ_TAKE if zero=1, else FETCH.
  - BRZ_TAKE [7]: aluop=00, alu_src_b=10, pc_write, pc_src=01. Next: FETCH.
  - C_EXEC [8]: aluop=10, alu_src_a=0, alu_src_b=01. Next: C_WB.
  - C_WB [9]: same ALU drive as C_EXEC, reg_write, mem_to_reg=0. reg_dst=1 when func[0]=1 (moveto), else reg_dst=0. Next: FETCH.
  - D_EXEC [10]: aluop=11, alu_src_a=0, alu_src_b=10. Next: D_WB.
  - D_WB [11]: same ALU drive as D_EXEC, reg_write, reg_dst=0, mem_to_reg=0. Next: FETCH.
  - States 12-15 are unreachable; if entered, go to FETCH with all enables 0.
- Cycles per instruction, FETCH included:
  - NOP / illegal: 2
  - STORE, JUMP: 3
  - BRZ not taken: 3
  - LOAD, BRZ taken, C, D: 4
- instr_count increments by 1 on every transition into FETCH from a state other than FETCH. It wraps modulo 2^CNT_W.
- Reset:
  - While rst_n=0: state=FETCH, instr_count=0, and pc_write, ir_write, mem_read, mem_write, reg_write are forced to 0. All other outputs take their FETCH values.
  - Reset asserted mid-instruction aborts it with no partial write. The first FETCH strobes appear in the first cycle after rst_n rises.
- zero is sampled only in BRZ_TEST; it is ignored in every other state.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles in any state -> state=0, instr_count=0, all write enables 0; after release, cycle 1 shows mem_read=ir_write=pc_write=1, pc_src=00.
- Type-D: opcode=1101 -> state sequence 0,1,10,11,0; aluop=11, alu_src_b=10 in states 10/11; reg_write=1 only in state 11; instr_count +1.
- Type-C: opcode=1000, func=9'h001 (moveto) -> C_WB with reg_dst=1, aluop=10. func=9'h000 -> 0,1,0 with no reg_write.
- Branch: opcode=0100 with zero=1 -> 0,1,6,7,0, pc_write=1 and pc_src=01 in state 7. With zero=0 -> 0,1,6,0 and no pc_write after FETCH.
- LOAD/STORE: opcode=0000 -> iord=1 in states 2,3, mem_to_reg=reg_write=1 in state 3. opcode=0001 -> mem_write=1 in state 4 only. Illegal opcode=0111 -> 0,1,0.
- Counter wrap: CNT_W=4, 16 NOPs -> instr_count returns to 0. Assert rst_n low during LOAD_RD -> no reg_write, counter cleared.
